// File: rtl/clock_time_ctrl_if.sv
// Button inputs and display/status outputs of the mm:ss clock controller.
// The controller connects through the slave modport; the stimulus side uses master.
interface clock_time_ctrl_if;
   logic       btn_mode;
   logic       btn_inc;
   logic [2:0] min10;
   logic [3:0] min;
   logic [2:0] sec10;
   logic [3:0] sec;
   logic [1:0] mode;
   logic       tick;
   logic       blank;

   modport master (
      output btn_mode, btn_inc,
      input  min10, min, sec10, sec, mode, tick, blank
   );

   modport slave (
      input  btn_mode, btn_inc,
      output min10, min, sec10, sec, mode, tick, blank
   );
endinterface

// File: rtl/clock_time_ctrl.sv
// BCD minutes:seconds clock with a run/set-minutes/set-seconds mode FSM, updated on the falling clock edge.
// Define CLOCK_TIME_CTRL_BLINK_EN to add the blink-phase register that drives blank while setting.
module clock_time_ctrl #(
   parameter int TICK_DIV = 50000000
) (
   input logic          clock,
   input logic          reset_n,
   clock_time_ctrl_if.slave bus
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

   localparam logic [1:0] RUN     = 2'b00;
   localparam logic [1:0] SET_MIN = 2'b01;
   localparam logic [1:0] SET_SEC = 2'b10;

   logic [CW-1:0] cnt;
   logic [1:0]    state;
   logic          prev_mode;
   logic          prev_inc;
   logic [2:0]    min10_q;
   logic [3:0]    min_q;
   logic [2:0]    sec10_q;
   logic [3:0]    sec_q;

   logic          tick;
   logic          mode_edge;
   logic          inc_edge;
   logic          sec_wrap;
   logic [6:0]    sec_next;
   logic [6:0]    min_next;

   // One BCD step 00..59; 59 and any out-of-range value fall back to 00.
   function automatic logic [6:0] bcd_step(input logic [2:0] tens, input logic [3:0] units);
      logic [6:0] r;
      if (tens > 3'd5 || units > 4'd9 || (tens == 3'd5 && units == 4'd9))
         r = 7'd0;
      else if (units == 4'd9)
         r = {tens + 3'd1, 4'd0};
      else
         r = {tens, units + 4'd1};
      return r;
   endfunction

   assign tick      = (cnt == CNT_LAST);
   assign mode_edge = bus.btn_mode & ~prev_mode;
   assign inc_edge  = bus.btn_inc & ~prev_inc & ~mode_edge;
   assign sec_next  = bcd_step(sec10_q, sec_q);
   assign min_next  = bcd_step(min10_q, min_q);
   assign sec_wrap  = (sec10_q == 3'd5) && (sec_q == 4'd9);

   // Prescaler also restarts when leaving SET_SEC so RUN resumes on a full second.
   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= '0;
         prev_mode <= 1'b1;
         prev_inc  <= 1'b1;
      end else begin
         prev_mode <= bus.btn_mode;
         prev_inc  <= bus.btn_inc;
         if (tick || (mode_edge && state == SET_SEC))
            cnt <= '0;
         else
            cnt <= cnt + CW'(1);
      end
   end

   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= RUN;
      end else if (mode_edge) begin
         case (state)
            RUN:     state <= SET_MIN;
            SET_MIN: state <= SET_SEC;
            default: state <= RUN;
         endcase
      end
   end

   // Time fields; the step applied depends on the mode in force before any transition.
   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         min10_q <= '0;
         min_q   <= '0;
         sec10_q <= '0;
         sec_q   <= '0;
      end else begin
         case (state)
            RUN: begin
               if (tick) begin
                  {sec10_q, sec_q} <= sec_next;
                  if (sec_wrap)
                     {min10_q, min_q} <= min_next;
               end
            end
            SET_MIN: begin
               if (inc_edge)
                  {min10_q, min_q} <= min_next;
            end
            SET_SEC: begin
               if (inc_edge)
                  {sec10_q, sec_q} <= sec_next;
            end
            default: ;
         endcase
      end
   end

`ifdef CLOCK_TIME_CTRL_BLINK_EN
   logic phase;

   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n)
         phase <= 1'b0;
      else if (mode_edge)
         phase <= 1'b0;
      else if (tick)
         phase <= ~phase;
   end

   assign bus.blank = (state != RUN) & phase;
`else
   assign bus.blank = 1'b0;
`endif

   assign bus.min10 = min10_q;
   assign bus.min   = min_q;
   assign bus.sec10 = sec10_q;
   assign bus.sec   = sec_q;
   assign bus.mode  = state;
   assign bus.tick  = tick;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl: directed scenarios plus random button traffic
// compared against an integer minutes/seconds reference model.
module tb_clock_time_ctrl;

   localparam int TICK_DIV = 4;

   logic clock;
   logic reset_n;
   clock_time_ctrl_if bus ();

   clock_time_ctrl #(.TICK_DIV(TICK_DIV)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: plain minute/second integers, mode number, cycles since prescaler clear.
   int mm, ms, mmode, since, mphase;
   bit pm, pi;

   int cyc = 0;
   int ticks_seen = 0;
   int last_tick = -1;
   bit check_period = 0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      tests++;
      if (observed !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   function automatic int obs_time();
      return int'(bus.min10) * 1000 + int'(bus.min) * 100 + int'(bus.sec10) * 10 + int'(bus.sec);
   endfunction

   task automatic model_reset();
      mm = 0; ms = 0; mmode = 0; since = 0; mphase = 0;
      pm = 1'b1; pi = 1'b1;
   endtask

   task automatic model_update(input bit bm, input bit bi);
      bit me, ie, tk;
      me = bm && !pm;
      ie = bi && !pi && !me;
      tk = (since % TICK_DIV) == (TICK_DIV - 1);
      case (mmode)
         0: if (tk) begin
               ms = ms + 1;
               if (ms == 60) begin
                  ms = 0;
                  mm = (mm + 1) % 60;
               end
            end
         1: if (ie) mm = (mm + 1) % 60;
         default: if (ie) ms = (ms + 1) % 60;
      endcase
      if (me && mmode == 2) since = 0;
      else since = since + 1;
      if (me) mphase = 0;
      else if (tk) mphase = 1 - mphase;
      if (me) mmode = (mmode + 1) % 3;
      pm = bm;
      pi = bi;
   endtask

   task automatic check_all();
      int exp_blank;
`ifdef CLOCK_TIME_CTRL_BLINK_EN
      exp_blank = (mmode != 0 && mphase == 1) ? 1 : 0;
`else
      exp_blank = 0;
`endif
      checkOutput("time", obs_time(), (mm / 10) * 1000 + (mm % 10) * 100 + (ms / 10) * 10 + (ms % 10));
      checkOutput("mode", int'(bus.mode), mmode);
      checkOutput("tick", int'(bus.tick), ((since % TICK_DIV) == (TICK_DIV - 1)) ? 1 : 0);
      checkOutput("blank", int'(bus.blank), exp_blank);
   endtask

   // One clock: inputs set after the rising edge, DUT updates on the falling edge, sampled at the next rising edge.
   task automatic applyStimulus(input bit bm, input bit bi);
      bus.btn_mode = bm;
      bus.btn_inc  = bi;
      @(negedge clock);
      model_update(bm, bi);
      @(posedge clock);
      cyc++;
      check_all();
      if (bus.tick) begin
         ticks_seen++;
         if (check_period && last_tick >= 0)
            checkOutput("tick_period", cyc - last_tick, TICK_DIV);
         last_tick = cyc;
      end
      #1;
   endtask

   task automatic press_inc();
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
   endtask

   task automatic press_mode();
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
   endtask

   // From RUN, load minutes then seconds; ends in SET_SEC.
   task automatic set_time(input int m, input int s);
      press_mode();
      for (int k = 0; k < 60 && mm != m; k++) press_inc();
      press_mode();
      for (int k = 0; k < 60 && ms != s; k++) press_inc();
   endtask

   task automatic do_reset(input bit hold_mode);
      reset_n = 1'b0;
      bus.btn_mode = hold_mode;
      bus.btn_inc  = 1'b0;
      model_reset();
      #1;
      check_all();
      checkOutput("reset_time", obs_time(), 0);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      int m0, s0;
      reset_n = 1'b0;
      bus.btn_mode = 1'b0;
      bus.btn_inc  = 1'b0;
      model_reset();
      @(posedge clock);
      #1;
      check_all();
      checkOutput("reset_mode", int'(bus.mode), 0);
      reset_n = 1'b1;

      // Free-running count: 240 cycles give 60 seconds.
      check_period = 1;
      ticks_seen = 0;
      last_tick = -1;
      repeat (240) applyStimulus(1'b0, 1'b0);
      check_period = 0;
      checkOutput("ticks_240", ticks_seen, 60);
      checkOutput("time_240", obs_time(), 100);

      // Preload 59:58, return to RUN, first tick lands four cycles later.
      set_time(59, 58);
      applyStimulus(1'b1, 1'b0);
      checkOutput("back_to_run", int'(bus.mode), 0);
      repeat (3) applyStimulus(1'b0, 1'b0);
      checkOutput("before_first_tick", obs_time(), 5958);
      applyStimulus(1'b0, 1'b0);
      checkOutput("first_tick", obs_time(), 5959);
      repeat (4) applyStimulus(1'b0, 1'b0);
      checkOutput("wrap_hour", obs_time(), 0);

      // Held inc counts once, then three distinct presses; seconds frozen.
      press_mode();
      m0 = mm;
      s0 = ms;
      repeat (10) applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
      repeat (3) press_inc();
      checkOutput("set_min_plus4", int'(bus.min10) * 10 + int'(bus.min), (m0 + 4) % 60);
      checkOutput("set_min_sec_hold", int'(bus.sec10) * 10 + int'(bus.sec), s0);
      press_mode();
      press_mode();

      // Seconds wrap without carry, then simultaneous mode+inc applies only the mode change.
      set_time(12, 59);
      press_inc();
      checkOutput("sec_wrap_nocarry", obs_time(), 1200);
      applyStimulus(1'b1, 1'b1);
      checkOutput("simul_mode", int'(bus.mode), 0);
      checkOutput("simul_time", obs_time(), 1200);
      applyStimulus(1'b0, 1'b0);

      // Reset mid-set with btn_mode held through release.
      set_time(7, 33);
      press_mode();
      applyStimulus(1'b1, 1'b0);
      checkOutput("pre_reset_time", obs_time(), 733);
      checkOutput("pre_reset_mode", int'(bus.mode), 1);
      do_reset(1'b1);
      repeat (3) applyStimulus(1'b1, 1'b0);
      checkOutput("post_reset_mode", int'(bus.mode), 0);
      applyStimulus(1'b0, 1'b0);

      // Blink phase while setting minutes.
      press_mode();
      repeat (12) applyStimulus(1'b0, 1'b0);
      press_mode();
      press_mode();

      // Random button traffic with one reset in the middle.
      for (int i = 0; i < 1500; i++) begin
         if (i == 750) do_reset(1'($urandom_range(0, 1)));
         applyStimulus(($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
